bus_burst_driver: RTL and testbench

Transmit side of the shared data bus: buffers words from a local producer in a small FIFO and drives them onto `BusOut` in arbitrated bursts, one word per cycle, with a write strobe for the receiving bus register. It sits between pointcloud datapath stages and the bus-loaded registers. It requests the bus, waits for grant, bursts up to `MAX_BURST` words, then releases the bus so other sources get a turn.

---
 rtl/bus_burst_driver.sv | 137 +++++++++++++
 tb/tb_bus_burst_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_burst_driver.sv
// Transmit side of the shared data bus: small circular FIFO from a local producer,
// drained onto BusOut in arbitrated bursts of at most MAX_BURST words per grant.
module bus_burst_driver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     Clk,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     bus_req,
    input  logic                     bus_gnt,
    output logic [WIDTH-1:0]         BusOut,
    output logic                     bus_we
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [BW-1:0]    r_burst;
    logic             r_full;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [WIDTH-1:0] r_bus_out;
    state_t           r_state;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic [BW-1:0]    w_burst_inc;
    logic [BW-1:0]    w_burst_nxt;
    state_t           w_state_nxt;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign w_push      = wr_en && (r_count != CW'(DEPTH));
    assign w_pop       = (r_state != S_IDLE) && bus_gnt && (r_count != '0)
                         && (r_burst < BW'(MAX_BURST));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_burst_inc = r_burst + BW'(1);

    // Next-state and burst counter decode.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_REQ;
                    w_burst_nxt = '0;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    if (w_pop) begin
                        w_burst_nxt = w_burst_inc;
                        w_state_nxt = ((w_count_nxt != '0) && (w_burst_inc < BW'(MAX_BURST)))
                                      ? S_DRIVE : S_IDLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DRIVE: begin
                if (!bus_gnt) begin
                    w_state_nxt = S_REQ;
                    w_burst_nxt = '0;
                end else if (w_pop) begin
                    w_burst_nxt = w_burst_inc;
                    w_state_nxt = ((w_count_nxt == '0) || (w_burst_inc >= BW'(MAX_BURST)))
                                  ? S_IDLE : S_DRIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_burst_nxt = '0;
            end
        endcase
    end

    // Storage needs no reset: emptiness is carried entirely by the pointers and count.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_burst   <= '0;
            r_full    <= 1'b0;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_bus_out <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_burst   <= w_burst_nxt;
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == CW'(DEPTH));
            r_bus_req <= (w_state_nxt != S_IDLE);
            r_bus_we  <= w_pop;
            r_bus_out <= w_pop ? r_mem[r_rptr] : '0;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    assign full    = r_full;
    assign count   = r_count;
    assign bus_req = r_bus_req;
    assign bus_we  = r_bus_we;
    assign BusOut  = r_bus_out;

endmodule

// File: tb/tb_bus_burst_driver.sv
// Directed cycle-by-cycle bench for bus_burst_driver (WIDTH=8, DEPTH=4, MAX_BURST=4).
module tb_bus_burst_driver;

    logic       Clk;
    logic       RST;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic [2:0] count;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] BusOut;
    logic       bus_we;

    int n_cmp;
    int n_err;

    bus_burst_driver #(.WIDTH(8), .DEPTH(4), .MAX_BURST(4)) dut (
        .Clk     (Clk),
        .RST     (RST),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .count   (count),
        .bus_req (bus_req),
        .bus_gnt (bus_gnt),
        .BusOut  (BusOut),
        .bus_we  (bus_we)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Word output check: {bus_we, BusOut}.
    task automatic check_word(input string tag, input logic we, input logic [7:0] data);
        check_eq(tag, {23'd0, bus_we, BusOut}, {23'd0, we, data});
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        RST     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        bus_gnt = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom_range(0, 255));
            bus_gnt = 1'($urandom_range(0, 1));
            tick();
            check_eq("reset_outs", {18'd0, full, count, bus_req, bus_we, BusOut}, 32'd0);
        end
        wr_en   = 1'b0;
        bus_gnt = 1'b0;
        RST     = 1'b1;

        // Single word with grant held high.
        bus_gnt = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        check_eq("single_cnt_after_push", {29'd0, count}, 32'd1);
        check_eq("single_req_low_k", {31'd0, bus_req}, 32'd0);
        tick();
        check_eq("single_req_k1", {31'd0, bus_req}, 32'd1);
        check_word("single_no_word_k1", 1'b0, 8'h00);
        tick();
        check_word("single_word", 1'b1, 8'hAA);
        check_eq("single_cnt_zero", {29'd0, count}, 32'd0);
        check_eq("single_req_drop", {31'd0, bus_req}, 32'd0);
        tick();
        check_word("single_strobe_once", 1'b0, 8'h00);

        // Burst limit: four queued without grant, a fifth pushed mid-burst.
        bus_gnt = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check_eq("burst_full", {28'd0, full, count}, {28'd0, 1'b1, 3'd4});
        check_eq("burst_req_waiting", {31'd0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        tick();
        check_word("burst_w1", 1'b1, 8'h01);
        check_eq("burst_cnt3", {28'd0, full, count}, {28'd0, 1'b0, 3'd3});
        wr_en   = 1'b1;
        wr_data = 8'h05;
        tick();
        wr_en = 1'b0;
        check_word("burst_w2", 1'b1, 8'h02);
        check_eq("burst_push_pop_cnt", {29'd0, count}, 32'd3);
        tick();
        check_word("burst_w3", 1'b1, 8'h03);
        tick();
        check_word("burst_w4", 1'b1, 8'h04);
        check_eq("burst_limit_req_low", {31'd0, bus_req}, 32'd0);
        check_eq("burst_left_cnt", {29'd0, count}, 32'd1);
        tick();
        check_word("burst_gap", 1'b0, 8'h00);
        check_eq("burst_rereq", {31'd0, bus_req}, 32'd1);
        tick();
        check_word("burst_w5", 1'b1, 8'h05);
        check_eq("burst_done_req", {31'd0, bus_req}, 32'd0);
        tick();
        check_word("burst_idle", 1'b0, 8'h00);

        // Full / drop: fifth push while full is lost.
        bus_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h10 + i);
            tick();
            if (i == 3) check_eq("drop_full_at4", {28'd0, full, count}, {28'd0, 1'b1, 3'd4});
        end
        wr_en = 1'b0;
        check_eq("drop_still_4", {28'd0, full, count}, {28'd0, 1'b1, 3'd4});
        bus_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_word("drop_drain", 1'b1, 8'(8'h10 + i));
        end
        check_eq("drop_empty", {28'd0, full, count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_word("drop_no_14", 1'b0, 8'h00);
        end

        // Grant dropped after the second word of a burst.
        bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h20 + i);
            tick();
        end
        wr_en   = 1'b0;
        bus_gnt = 1'b1;
        tick();
        check_word("gdrop_w0", 1'b1, 8'h20);
        tick();
        check_word("gdrop_w1", 1'b1, 8'h21);
        bus_gnt = 1'b0;
        tick();
        check_word("gdrop_none", 1'b0, 8'h00);
        check_eq("gdrop_req_held", {31'd0, bus_req}, 32'd1);
        check_eq("gdrop_cnt", {29'd0, count}, 32'd2);
        tick();
        check_word("gdrop_none2", 1'b0, 8'h00);
        bus_gnt = 1'b1;
        tick();
        check_word("gdrop_w2", 1'b1, 8'h22);
        tick();
        check_word("gdrop_w3", 1'b1, 8'h23);
        check_eq("gdrop_req_end", {31'd0, bus_req}, 32'd0);
        tick();
        check_word("gdrop_idle", 1'b0, 8'h00);

        // Asynchronous reset in the middle of a burst.
        bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h30 + i);
            tick();
        end
        wr_en   = 1'b0;
        bus_gnt = 1'b1;
        tick();
        check_word("rstm_w0", 1'b1, 8'h30);
        #2;
        RST = 1'b0;
        #1;
        check_eq("rstm_async_clear", {18'd0, full, count, bus_req, bus_we, BusOut}, 32'd0);
        tick();
        tick();
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rstm_quiet", {29'd0, count, bus_req, bus_we}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
